// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA raster scanner with registered TinyVGA pin stage; optional auto-cycle via FLAG_AUTOCYCLE_EN
module vga_scan_out #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int NUM_FLAGS    = 16,
  parameter int CYCLE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] color_in,
  input  logic [3:0] sel_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [3:0] flag_sel,
  output logic [7:0] frame_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Full 10-bit constants so every counter comparison uses the whole value
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0] FLAG_LAST = 4'(NUM_FLAGS - 1);

  logic eof;
  logic active;
  logic hs;
  logic vs;

  // Decode the current counter position into frame end, visible region and sync windows
  always_comb begin
    eof    = (pix_x == H_LAST) && (pix_y == V_LAST);
    active = (pix_x < H_ACT) && (pix_y < V_ACT);
    hs     = (pix_x >= HS_FIRST) && (pix_x <= HS_LAST);
    vs     = (pix_y >= VS_FIRST) && (pix_y <= VS_LAST);
  end

  // Raster counters: x every clock, y on each line wrap, both wrap together at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (pix_x == H_LAST) begin
      pix_x <= '0;
      pix_y <= (pix_y == V_LAST) ? '0 : pix_y + 10'd1;
    end else begin
      pix_x <= pix_x + 10'd1;
    end
  end

  // Completed-frame counter, naturally wrapping at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (eof) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef FLAG_AUTOCYCLE_EN
  localparam int DIV_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLE_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             unused_sel;

  // The requested index has no role when the flags advance on their own
  assign unused_sel = ^sel_in;

  // Advance to the next flag once every CYCLE_FRAMES frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      flag_sel <= '0;
    end else if (eof) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        flag_sel <= (flag_sel == FLAG_LAST) ? '0 : flag_sel + 4'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
`else
  localparam logic [4:0] NUM_FLAGS_W = 5'(NUM_FLAGS);

  // Take the requested flag only at frame end so a frame never mixes two flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_sel <= '0;
    end else if (eof) begin
      flag_sel <= ({1'b0, sel_in} < NUM_FLAGS_W) ? sel_in : '0;
    end
  end
`endif

  // Pin stage: one clock behind the counters, blanking forces black, syncs active low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      {r, g, b} <= active ? color_in : 6'd0;
      hsync     <= ~hs;
      vsync     <= ~vs;
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// tb/tb_vga_scan_out.sv - self-checking bench for vga_scan_out on a reduced raster
module tb_vga_scan_out;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef FLAG_AUTOCYCLE_EN
  localparam int NF = 3;
`else
  localparam int NF = 8;
`endif
  localparam int CF = 2;

  logic       clk;
  logic       rst_n;
  logic [5:0] color_in;
  logic [3:0] sel_in;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [3:0] flag_sel;
  logic [7:0] frame_cnt;
  logic       hsync;
  logic       vsync;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .NUM_FLAGS(NF), .CYCLE_FRAMES(CF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .color_in(color_in), .sel_in(sel_in),
    .pix_x(pix_x), .pix_y(pix_y), .flag_sel(flag_sel), .frame_cnt(frame_cnt),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Reference model state: position in frame as a plain cycle index
  int         t;
  logic [7:0] m_frame;
  logic [3:0] m_flag;
  int         m_div;
  logic [5:0] m_rgb;
  logic       m_hs_n;
  logic       m_vs_n;
  bit         rand_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int x;
    int y;
    bit eof;
    bit act;
    bit in_hs;
    bit in_vs;
    x     = t % HT;
    y     = t / HT;
    eof   = (x == HT - 1) && (y == VT - 1);
    act   = (x < HA) && (y < VA);
    in_hs = (x >= HA + HF) && (x < HA + HF + HS);
    in_vs = (y >= VA + VF) && (y < VA + VF + VS);
    @(posedge clk);
    #1;
    m_rgb  = act ? color_in : 6'd0;
    m_hs_n = !in_hs;
    m_vs_n = !in_vs;
    if (eof) begin
      m_frame = m_frame + 8'd1;
`ifdef FLAG_AUTOCYCLE_EN
      if (m_div == CF - 1) begin
        m_div  = 0;
        m_flag = (int'(m_flag) == NF - 1) ? 4'd0 : m_flag + 4'd1;
      end else begin
        m_div = m_div + 1;
      end
`else
      m_flag = (int'(sel_in) < NF) ? sel_in : 4'd0;
`endif
    end
    t = (t + 1) % FRAME;
    check("pos", 32'({pix_x, pix_y}), 32'({10'(t % HT), 10'(t / HT)}));
    check("pins", 32'({hsync, vsync, r, g, b}), 32'({m_hs_n, m_vs_n, m_rgb}));
    check("frame", 32'({flag_sel, frame_cnt}), 32'({m_flag, m_frame}));
    color_in = 6'($urandom);
    if (rand_sel) sel_in = 4'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, 32'({pix_x, pix_y, flag_sel, frame_cnt}), 32'd0);
    check(tag, 32'({hsync, vsync, r, g, b}), 32'({1'b1, 1'b1, 6'd0}));
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    t        = 0;
    m_frame  = '0;
    m_flag   = '0;
    m_div    = 0;
    rand_sel = 0;
    rst_n    = 1'b0;
    color_in = 6'b110100;
    sel_in   = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // First frame with constant color; frame_cnt must read 1 afterwards
    step();
    check("first_x", 32'(pix_x), 32'd1);
    repeat (FRAME - 1) step();
    check("frame_one", 32'(frame_cnt), 32'd1);

`ifndef FLAG_AUTOCYCLE_EN
    // Mid-frame sel_in change takes effect only on the eof edge
    repeat (4 * HT) step();
    sel_in = 4'd5;
    repeat (FRAME - 4 * HT - 1) step();
    check("sel_hold", 32'(flag_sel), 32'd0);
    step();
    check("sel_take", 32'(flag_sel), 32'd5);
    // Out-of-range request selects flag 0
    sel_in = 4'd15;
    repeat (FRAME) step();
    check("sel_range", 32'(flag_sel), 32'd0);
`else
    repeat (2 * FRAME) step();
`endif

    // Random colors and random flag requests
    rand_sel = 1;
    repeat (3 * FRAME) step();
    rand_sel = 0;
    sel_in   = 4'd3;

    // Reset in the middle of a line mid-frame
    repeat (3 * HT + 5) step();
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_values("reset_hold");
    end
    rst_n   = 1'b1;
    t       = 0;
    m_frame = '0;
    m_flag  = '0;
    m_div   = 0;

    // 256 frames: frame_cnt wraps back to 0 with syncs checked every cycle
    repeat (256 * FRAME) step();
    check("frame_wrap", 32'(frame_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
